// File: rtl/serial_word_fifo.sv
// rtl/serial_word_fifo.sv - serial bit deserializer feeding a word FIFO
//
// Purpose:
//   Assembles WIDTH-bit words from a strobed serial bit stream and queues
//   them in a DEPTH-entry first-word-fall-through FIFO, all in one clock domain.
//
// Ports:
//   clock          system clock, all state on rising edge
//   reset          asynchronous active-low reset
//   data_in        serial bit, sampled when write_in is high
//   write_in       bit strobe, accepted while status_out is high
//   status_out     ready to accept bits (FIFO not full)
//   dequeue_in     pop request (edge or level, per DEQ_EDGE)
//   clear_in       synchronous flush
//   data_out       head word, 0 when empty
//   len_out        number of stored words, 0..DEPTH
//   full_out       len_out == DEPTH
//   empty_out      len_out == 0
//   overflow_out   sticky: bit strobed while not ready
//   underflow_out  sticky: pop requested while empty

module serial_word_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int DEQ_EDGE  = 1,
  parameter int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  output logic             status_out,
  input  logic             dequeue_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] data_out,
  output logic [LEN_W-1:0] len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             overflow_out,
  output logic             underflow_out
);

  localparam int PTR_W = LEN_W - 1;
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LEN_W-1:0] len;
  logic             overflow;
  logic             underflow;
  logic             deq_q;

  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop_req;
  logic             pop_ok;
  logic [CNT_W-1:0] bit_idx;
  logic [WIDTH-1:0] assembled;

  assign full   = (len == LEN_W'(DEPTH));
  assign empty  = (len == '0);
  assign accept = write_in & ~full;
  // Full is only reached on a push, so the bit counter is 0 whenever a
  // strobe is dropped and no partial word is ever lost to back-pressure.
  assign push   = accept & (bit_cnt == CNT_W'(WIDTH - 1));

  assign pop_req = (DEQ_EDGE != 0) ? (dequeue_in & ~deq_q) : dequeue_in;
  assign pop_ok  = pop_req & ~empty;

  assign bit_idx = (MSB_FIRST != 0) ? (CNT_W'(WIDTH - 1) - bit_cnt) : bit_cnt;

  // Word including the bit arriving this cycle; pushed as-is on the last bit.
  always_comb begin
    assembled          = shreg;
    assembled[bit_idx] = data_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      deq_q     <= 1'b0;
    end else if (clear_in) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      // Keep tracking the input so a level held across the flush does not
      // look like a fresh edge afterwards.
      deq_q     <= dequeue_in;
    end else begin
      deq_q <= dequeue_in;

      if (accept) begin
        if (push) begin
          bit_cnt <= '0;
          shreg   <= '0;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          shreg   <= assembled;
        end
      end

      if (write_in && full)
        overflow <= 1'b1;

      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);

      // A pop against an empty queue is ignored even if a push lands on
      // the same edge.
      if (pop_req && empty)
        underflow <= 1'b1;

      if (push && !pop_ok)
        len <= len + LEN_W'(1);
      else if (pop_ok && !push)
        len <= len - LEN_W'(1);
    end
  end

  // Storage array carries no reset; validity is tracked by len.
  always_ff @(posedge clock) begin
    if (!clear_in && push)
      mem[wr_ptr] <= assembled;
  end

  assign status_out    = ~full;
  assign full_out      = full;
  assign empty_out     = empty;
  assign len_out       = len;
  assign overflow_out  = overflow;
  assign underflow_out = underflow;
  assign data_out      = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_serial_word_fifo.sv
// tb/tb_serial_word_fifo.sv - directed self-checking bench for serial_word_fifo

module tb_serial_word_fifo;

  logic       clock;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       dequeue_in;
  logic       clear_in;

  logic       status_a, full_a, empty_a, ovf_a, unf_a;
  logic [7:0] data_a;
  logic [3:0] len_a;

  logic       status_m, full_m, empty_m, ovf_m, unf_m;
  logic [7:0] data_m;
  logic [3:0] len_m;

  logic       status_l, full_l, empty_l, ovf_l, unf_l;
  logic [7:0] data_l;
  logic [3:0] len_l;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] q[$];
  logic [7:0] w;

  serial_word_fifo dut (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(status_a), .dequeue_in(dequeue_in), .clear_in(clear_in),
    .data_out(data_a), .len_out(len_a), .full_out(full_a), .empty_out(empty_a),
    .overflow_out(ovf_a), .underflow_out(unf_a)
  );

  serial_word_fifo #(.MSB_FIRST(1)) dut_msb (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(status_m), .dequeue_in(dequeue_in), .clear_in(clear_in),
    .data_out(data_m), .len_out(len_m), .full_out(full_m), .empty_out(empty_m),
    .overflow_out(ovf_m), .underflow_out(unf_m)
  );

  serial_word_fifo #(.DEQ_EDGE(0)) dut_lvl (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(status_l), .dequeue_in(dequeue_in), .clear_in(clear_in),
    .data_out(data_l), .len_out(len_l), .full_out(full_l), .empty_out(empty_l),
    .overflow_out(ovf_l), .underflow_out(unf_l)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic b);
    @(negedge clock);
    data_in  = b;
    write_in = 1'b1;
    @(posedge clock);
    #1;
    write_in = 1'b0;
  endtask

  // Bits go out LSB first, so the MSB_FIRST=0 instance rebuilds wd unchanged.
  task automatic send_word(input logic [7:0] wd);
    for (int i = 0; i < 8; i++) strobe(wd[i]);
  endtask

  // Last bit of the word coincides with a one-cycle dequeue pulse.
  task automatic send_word_pop(input logic [7:0] wd);
    for (int i = 0; i < 7; i++) strobe(wd[i]);
    @(negedge clock);
    data_in    = wd[7];
    write_in   = 1'b1;
    dequeue_in = 1'b1;
    @(posedge clock);
    #1;
    write_in = 1'b0;
    @(negedge clock);
    dequeue_in = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear_in = 1'b1;
    @(posedge clock);
    #1;
    clear_in = 1'b0;
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0; data_in = 1'b0; write_in = 1'b0;
    dequeue_in = 1'b0; clear_in = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_len",    len_a,    4'd0);
    check("rst_empty",  empty_a,  1'b1);
    check("rst_full",   full_a,   1'b0);
    check("rst_status", status_a, 1'b1);
    check("rst_data",   data_a,   8'h00);
    check("rst_ovf",    ovf_a,    1'b0);
    check("rst_unf",    unf_a,    1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Reset mid-word with one word already stored
    send_word(8'h3C);
    check("t1_pre_len",  len_a,  4'd1);
    check("t1_pre_data", data_a, 8'h3C);
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t1_len",    len_a,    4'd0);
    check("t1_empty",  empty_a,  1'b1);
    check("t1_status", status_a, 1'b1);
    check("t1_data",   data_a,   8'h00);
    @(negedge clock);
    reset = 1'b1;
    send_word(8'hA5);
    check("t1_fresh_len",  len_a,  4'd1);
    check("t1_fresh_data", data_a, 8'hA5);

    // Bit order
    do_clear();
    send_word(8'h99);
    check("t2_len",      len_a,  4'd1);
    check("t2_data",     data_a, 8'h99);
    check("t2_msb_data", data_m, 8'h99);
    do_clear();
    send_word(8'h01);
    check("t2_lsb01", data_a, 8'h01);
    check("t2_msb80", data_m, 8'h80);

    // Fill, overflow, clear
    do_clear();
    for (int k = 0; k < 8; k++) send_word(8'h10 + 8'(k));
    check("t3_full",   full_a,   1'b1);
    check("t3_status", status_a, 1'b0);
    check("t3_len",    len_a,    4'd8);
    check("t3_ovf0",   ovf_a,    1'b0);
    send_word(8'hFF);
    check("t3_ovf",      ovf_a,  1'b1);
    check("t3_len_hold", len_a,  4'd8);
    check("t3_head",     data_a, 8'h10);
    do_clear();
    check("t3_clr_len",    len_a,    4'd0);
    check("t3_clr_ovf",    ovf_a,    1'b0);
    check("t3_clr_full",   full_a,   1'b0);
    check("t3_clr_status", status_a, 1'b1);

    // Held dequeue: edge mode pops once, level mode drains then underflows
    do_clear();
    send_word(8'hA1); send_word(8'hA2); send_word(8'hA3);
    check("t4_len3", len_a, 4'd3);
    @(negedge clock);
    dequeue_in = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) begin
        check("t4_edge_c1", len_a, 4'd2);
        check("t4_lvl_c1",  len_l, 4'd2);
      end
      if (c == 2) check("t4_lvl_c2", len_l, 4'd1);
      if (c == 3) begin
        check("t4_lvl_c3",     len_l, 4'd0);
        check("t4_lvl_unf_c3", unf_l, 1'b0);
      end
      if (c == 4) check("t4_lvl_unf_c4", unf_l, 1'b1);
    end
    check("t4_edge_len",  len_a,  4'd2);
    check("t4_edge_head", data_a, 8'hA2);
    check("t4_edge_unf",  unf_a,  1'b0);
    @(negedge clock);
    dequeue_in = 1'b0;

    // Simultaneous push and pop across pointer wrap
    do_clear();
    q = {};
    send_word(8'hB0); q.push_back(8'hB0);
    send_word(8'hB1); q.push_back(8'hB1);
    check("t5_len2", len_a, 4'd2);
    for (int p = 0; p < 21; p++) begin
      w = 8'(8'h40 + p * 7);
      check("t5_head_pre", data_a, q[0]);
      send_word_pop(w);
      void'(q.pop_front());
      q.push_back(w);
      check("t5_len", len_a, 4'd2);
    end
    check("t5_head_end", data_a, q[0]);
    check("t5_unf",      unf_a,  1'b0);

    // Clear mid-word
    do_clear();
    for (int i = 0; i < 5; i++) strobe(1'b1);
    do_clear();
    send_word(8'h6B);
    check("t6_len",      len_a,  4'd1);
    check("t6_data",     data_a, 8'h6B);
    check("t6_msb_data", data_m, 8'hD6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
